rr_sel_arbiter: RTL and testbench

Four-requester round-robin arbiter that issues a 2-bit encoded grant index plus a valid strobe. It sits directly upstream of the 2-to-4 decoder stage, which turns `sel` and `sel_valid` back into a one-hot enable. A grant ends in one of three ways: the grantee releases, the grantee drops its request, or the grant is pre-empted by a hold-time limit. A mandatory one-cycle dead gap between grants guarantees the downstream one-hot is never double-hot across a handover.

---
 rtl/rr_sel_arbiter.sv | 157 +++++++++++++++
 tb/tb_rr_sel_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rr_sel_arbiter.sv
// rr_sel_arbiter: four-requester round-robin arbiter with encoded grant,
// hold-time pre-emption and a one-cycle dead gap between grants.
//
// Parameters:
//   HOLD_MAX     max cycles o_sel_valid stays high for one grant (1..255)
// Ports:
//   i_clk        rising-edge clock
//   i_rst        asynchronous active-high reset
//   i_req[3:0]   request vector, bit i belongs to requester i
//   i_release    current grantee is done (only looked at while granting)
//   o_sel[1:0]   index of the granted requester (registered)
//   o_sel_valid  high while o_sel is a live grant (registered)
//   o_preempt    one-cycle pulse in the gap after a hold-limit pre-emption

module rr_sel_arbiter #(
    parameter int HOLD_MAX = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_release,
    output logic [1:0] o_sel,
    output logic       o_sel_valid,
    output logic       o_preempt
);

    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);
    localparam logic [HW-1:0] HCNT_ONE = HW'(1);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rr_sel_arbiter: HOLD_MAX out of range 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // registered state
    state_t        r_state;
    logic [1:0]    r_ptr;
    logic [HW-1:0] r_hcnt;
    logic [1:0]    r_sel;
    logic          r_sel_valid;
    logic          r_preempt;

    // next-state values
    state_t        w_state_nx;
    logic [1:0]    w_ptr_nx;
    logic [HW-1:0] w_hcnt_nx;
    logic [1:0]    w_sel_nx;
    logic          w_sel_valid_nx;
    logic          w_preempt_nx;

    // arbitration result
    logic          w_any_req;
    logic [1:0]    w_pick;
    logic [1:0]    w_idx;

    // grant-end conditions
    logic          w_owner_req;
    logic          w_normal_end;
    logic          w_hold_hit;
    logic [1:0]    w_ptr_after;

    // Rotating priority scan: ptr has the highest priority, then ptr+1,
    // ptr+2, ptr+3, all modulo 4 via the 2-bit wrap of the index.
    always_comb begin
        w_any_req = 1'b0;
        w_pick    = r_ptr;
        w_idx     = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_any_req && i_req[w_idx]) begin
                w_any_req = 1'b1;
                w_pick    = w_idx;
            end
        end
    end

    // A dropped request from the grantee counts as a normal end, same as
    // release; both take priority over the hold limit.
    assign w_owner_req  = i_req[r_sel];
    assign w_normal_end = i_release || !w_owner_req;
    assign w_hold_hit   = (r_hcnt == HOLD_LIM);
    assign w_ptr_after  = r_sel + 2'd1;

    always_comb begin
        w_state_nx     = r_state;
        w_ptr_nx       = r_ptr;
        w_hcnt_nx      = r_hcnt;
        w_sel_nx       = r_sel;
        w_sel_valid_nx = r_sel_valid;
        w_preempt_nx   = 1'b0;

        unique case (r_state)
            ST_GRANT: begin
                if (w_normal_end) begin
                    w_sel_valid_nx = 1'b0;
                    w_ptr_nx       = w_ptr_after;
                    w_state_nx     = ST_GAP;
                end else if (w_hold_hit) begin
                    w_sel_valid_nx = 1'b0;
                    w_ptr_nx       = w_ptr_after;
                    w_state_nx     = ST_GAP;
                    w_preempt_nx   = 1'b1;
                end else begin
                    w_hcnt_nx = r_hcnt + HCNT_ONE;
                end
            end

            // IDLE and GAP arbitrate identically; GAP exists only so the
            // valid strobe is low for one cycle between grants.
            ST_IDLE, ST_GAP: begin
                if (w_any_req) begin
                    w_sel_nx       = w_pick;
                    w_sel_valid_nx = 1'b1;
                    w_hcnt_nx      = HCNT_ONE;
                    w_state_nx     = ST_GRANT;
                end else begin
                    w_sel_valid_nx = 1'b0;
                    w_state_nx     = ST_IDLE;
                end
            end

            default: begin
                w_sel_valid_nx = 1'b0;
                w_state_nx     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd0;
            r_hcnt      <= '0;
            r_sel       <= 2'd0;
            r_sel_valid <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_hcnt      <= w_hcnt_nx;
            r_sel       <= w_sel_nx;
            r_sel_valid <= w_sel_valid_nx;
            r_preempt   <= w_preempt_nx;
        end
    end

    assign o_sel       = r_sel;
    assign o_sel_valid = r_sel_valid;
    assign o_preempt   = r_preempt;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// tb_rr_sel_arbiter: directed bench for rr_sel_arbiter (HOLD_MAX=4).
// Each step pushes the hand-derived expected outputs, then compares.

module tb_rr_sel_arbiter;

    localparam int HM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'd0;
    logic       rel = 1'b0;
    logic [1:0] sel;
    logic       sel_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] sel;
        logic       v;
        logic       p;
    } exp_t;

    exp_t sb[$];

    logic [1:0] order [9] = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3,
                              2'd0, 2'd1, 2'd2, 2'd3};

    rr_sel_arbiter #(.HOLD_MAX(HM)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_release   (rel),
        .o_sel       (sel),
        .o_sel_valid (sel_valid),
        .o_preempt   (preempt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string tag, input logic [1:0] es,
                              input logic ev, input logic ep);
        exp_t e;
        e.tag = tag;
        e.sel = es;
        e.v   = ev;
        e.p   = ep;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (sel === e.sel) else begin
            errors++;
            $error("FAIL %s sel: observed %0d expected %0d",
                   e.tag, sel, e.sel);
        end
        checks++;
        assert (sel_valid === e.v) else begin
            errors++;
            $error("FAIL %s sel_valid: observed %0b expected %0b",
                   e.tag, sel_valid, e.v);
        end
        checks++;
        assert (preempt === e.p) else begin
            errors++;
            $error("FAIL %s preempt: observed %0b expected %0b",
                   e.tag, preempt, e.p);
        end
    endtask

    // drive inputs for the coming edge; outputs after it must match
    task automatic step(input string tag, input logic [3:0] r,
                        input logic rl, input logic [1:0] es,
                        input logic ev, input logic ep);
        req = r;
        rel = rl;
        expect_out(tag, es, ev, ep);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        // power-on reset
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_out("por", 2'd0, 1'b0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // idle stays idle; release in IDLE is ignored
        step("idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("idle_rel", 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);

        // grant requester 2, then reset asynchronously mid-grant
        step("g2_c1", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        step("g2_c2", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 2'd0, 1'b0, 1'b0);
        check_out();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_rst0", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
        step("post_rst1", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // single requester, release on 3rd grant cycle
        step("sr_c1", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        step("sr_c2", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        step("sr_c3", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        step("sr_gap", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        step("sr_regrant", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
        step("sr_end", 4'b0100, 1'b1, 2'd2, 1'b0, 1'b0);
        step("sr_idle", 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);

        // round robin: ptr=3 from above, so order starts at 3
        for (int i = 0; i < 9; i++) begin
            step("rr_c1", 4'b1111, 1'b0, order[i], 1'b1, 1'b0);
            step("rr_c2", 4'b1111, 1'b0, order[i], 1'b1, 1'b0);
            step("rr_gap", 4'b1111, 1'b1, order[i], 1'b0, 1'b0);
        end
        step("rr_idle", 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);

        // pre-emption at HOLD_MAX=4 with ptr=0
        for (int i = 0; i < HM; i++)
            step("pre_g0", 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
        step("pre_p0", 4'b0011, 1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < HM; i++)
            step("pre_g1", 4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);
        step("pre_p1", 4'b0011, 1'b0, 2'd1, 1'b0, 1'b1);
        step("pre_next", 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);

        // release on the same cycle hcnt reaches HOLD_MAX
        step("sim_c2", 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
        step("sim_c3", 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
        step("sim_c4", 4'b0011, 1'b0, 2'd0, 1'b1, 1'b0);
        step("sim_rel_max", 4'b0011, 1'b1, 2'd0, 1'b0, 1'b0);
        step("sim_ptr", 4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);

        // grantee drops its request mid-grant
        step("drop_c2", 4'b0011, 1'b0, 2'd1, 1'b1, 1'b0);
        step("drop_gap", 4'b0001, 1'b0, 2'd1, 1'b0, 1'b0);
        step("drop_next", 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0);

        // release and request drop together: one normal end
        step("rel_drop", 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
        step("rel_drop_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // wrap-around: grant 3 ends, ptr wraps to 0; release in GAP ignored
        step("wrap_g3", 4'b1000, 1'b0, 2'd3, 1'b1, 1'b0);
        step("wrap_end", 4'b1001, 1'b1, 2'd3, 1'b0, 1'b0);
        step("wrap_next", 4'b1001, 1'b1, 2'd0, 1'b1, 1'b0);
        step("wrap_c2", 4'b1001, 1'b0, 2'd0, 1'b1, 1'b0);
        step("end_gap", 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
        step("end_idle", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
